// File: rtl/sc_gray_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy/flags and Gray-coded
// pointer exports for downstream clock-domain-crossing logic.
module sc_gray_fifo #(
  parameter int LOG_DEPTH          = 5,
  parameter int WIDTH              = 20,
  parameter int NUM_WORDS          = 2**LOG_DEPTH - 1,
  parameter int ALMOST_FULL_VALUE  = 30,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 wrreq,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  output logic [WIDTH-1:0]     q,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [LOG_DEPTH-1:0] usedw,
  output logic [LOG_DEPTH-1:0] gray_wr_ptr,
  output logic [LOG_DEPTH-1:0] gray_rd_ptr
);

  localparam int DEPTH = 2**LOG_DEPTH;

  generate
    if (LOG_DEPTH < 3 || LOG_DEPTH > 5 ||
        NUM_WORDS < 1 || NUM_WORDS > DEPTH - 1 ||
        ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH - 1 ||
        ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH - 1) begin : g_bad_params
      $error("sc_gray_fifo: parameter out of legal range");
    end
  endgenerate

  localparam logic [LOG_DEPTH-1:0] FULL_LEVEL = LOG_DEPTH'(NUM_WORDS);
  localparam logic [LOG_DEPTH-1:0] AF_LEVEL   = LOG_DEPTH'(ALMOST_FULL_VALUE);
  localparam logic [LOG_DEPTH-1:0] AE_LEVEL   = LOG_DEPTH'(ALMOST_EMPTY_VALUE);

  function automatic logic [LOG_DEPTH-1:0] to_gray(input logic [LOG_DEPTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  logic [LOG_DEPTH-1:0] wptr, rptr, usedw_next;
  logic [LOG_DEPTH-1:0] wr_inc, rd_inc, rd_hold;
  logic                 wr_ok, rd_ok;
  logic [WIDTH-1:0]     mem [DEPTH];

  // Gating uses the registered flags, so a full FIFO drops a write even when
  // a read is accepted in the same cycle.
  assign wr_ok   = wrreq & ~full;
  assign rd_ok   = rdreq & ~empty;
  assign wr_inc  = {{(LOG_DEPTH-1){1'b0}}, wr_ok};
  assign rd_inc  = {{(LOG_DEPTH-1){1'b0}}, rd_ok};
  assign rd_hold = {{(LOG_DEPTH-1){1'b0}}, ~rd_ok};

  // Four-input adder: wptr + ~rptr + wr_ok + ~rd_ok == wptr - rptr + wr_ok - rd_ok.
  assign usedw_next = wptr + ~rptr + wr_inc + rd_hold;

  // NOTE: flags are derived from usedw_next rather than usedw so that the
  // registered flags and the registered count always describe the same cycle.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wptr         <= '0;
      rptr         <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      gray_wr_ptr  <= '0;
      gray_rd_ptr  <= '0;
    end else begin
      wptr         <= wptr + wr_inc;
      rptr         <= rptr + rd_inc;
      usedw        <= usedw_next;
      empty        <= (usedw_next == '0);
      full         <= (usedw_next == FULL_LEVEL);
      almost_empty <= (usedw_next < AE_LEVEL);
      almost_full  <= (usedw_next >= AF_LEVEL);
      gray_wr_ptr  <= to_gray(wptr);
      gray_rd_ptr  <= to_gray(rptr);
    end
  end

  // NOTE: the storage array has no reset so it maps onto distributed RAM;
  // clearing the pointers is enough to discard its contents logically.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wptr] <= data;
  end

  assign q = mem[rptr];

endmodule

// File: tb/tb_sc_gray_fifo.sv
// Self-checking bench for sc_gray_fifo: queue-based reference model with
// directed fill/drain, simultaneous, wrap, Gray, mid-reset and random traffic.
module tb_sc_gray_fifo;

  localparam int LD  = 5;
  localparam int W   = 20;
  localparam int NUM = 31;
  localparam int AF  = 30;
  localparam int AE  = 2;

  logic          clock = 1'b0;
  logic          aclr_n = 1'b1;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [W-1:0]  data = '0;
  logic [W-1:0]  q;
  logic          empty, full, almost_empty, almost_full;
  logic [LD-1:0] usedw, gray_wr_ptr, gray_rd_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue, pointers as plain counters.
  logic [W-1:0]  mq[$];
  int            wp = 0;
  int            rp = 0;
  logic [LD-1:0] exp_gw = '0;
  logic [LD-1:0] exp_gr = '0;

  sc_gray_fifo dut (
    .clock(clock), .aclr_n(aclr_n), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .usedw(usedw),
    .gray_wr_ptr(gray_wr_ptr), .gray_rd_ptr(gray_rd_ptr)
  );

  always #5 clock = ~clock;

  function automatic logic [LD-1:0] gray_of(input int v);
    logic [LD-1:0] b;
    b = LD'(v % 32);
    return b ^ (b >> 1);
  endfunction

  // Drives one cycle of requests, advances the model, returns #1 after the edge.
  task automatic step(input bit wr, input bit rd, input logic [W-1:0] d);
    bit wok, rok;
    wrreq = wr; rdreq = rd; data = d;
    wok = wr && (mq.size() < NUM);
    rok = rd && (mq.size() > 0);
    exp_gw = gray_of(wp);
    exp_gr = gray_of(rp);
    @(posedge clock); #1;
    if (rok) begin void'(mq.pop_front()); rp = (rp + 1) % 32; end
    if (wok) begin mq.push_back(d);       wp = (wp + 1) % 32; end
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete(); wp = 0; rp = 0; exp_gw = '0; exp_gr = '0;
  endtask

  task automatic pulse_reset();
    aclr_n = 1'b0; #1; aclr_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    #1 aclr_n = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1)        begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0)         begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
    n_checks++; if (almost_full !== 1'b0)  begin n_fail++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    n_checks++; if (usedw !== 5'd0)        begin n_fail++; $display("FAIL reset_usedw: got %0d want 0", usedw); end
    n_checks++; if (gray_wr_ptr !== 5'd0)  begin n_fail++; $display("FAIL reset_gwr: got %h want 0", gray_wr_ptr); end
    n_checks++; if (gray_rd_ptr !== 5'd0)  begin n_fail++; $display("FAIL reset_grd: got %h want 0", gray_rd_ptr); end
    #5 aclr_n = 1'b1;
    model_clear();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= NUM; i++) begin
      step(1'b1, 1'b0, W'(i));
      n_checks++; if (usedw !== LD'(i)) begin n_fail++; $display("FAIL fill_usedw: got %0d want %0d", usedw, i); end
      n_checks++; if (almost_full !== (i >= AF)) begin n_fail++; $display("FAIL fill_afull: got %b at level %0d", almost_full, i); end
      n_checks++; if (full !== (i == NUM)) begin n_fail++; $display("FAIL fill_full: got %b at level %0d", full, i); end
      n_checks++; if (empty !== 1'b0 || almost_empty !== (i < AE)) begin n_fail++; $display("FAIL fill_empty_flags: got %b/%b at level %0d", empty, almost_empty, i); end
      n_checks++; if (q !== 20'h00001) begin n_fail++; $display("FAIL fill_q_head: got %h want 00001", q); end
    end
    step(1'b1, 1'b0, 20'hABCDE);
    n_checks++; if (usedw !== 5'd31 || full !== 1'b1) begin n_fail++; $display("FAIL overflow_drop: usedw %0d full %b want 31/1", usedw, full); end
    for (int i = 1; i <= NUM; i++) begin
      n_checks++; if (q !== W'(i)) begin n_fail++; $display("FAIL drain_q: got %h want %h", q, W'(i)); end
      step(1'b0, 1'b1, '0);
      n_checks++; if (usedw !== LD'(NUM - i)) begin n_fail++; $display("FAIL drain_usedw: got %0d want %0d", usedw, NUM - i); end
      n_checks++; if (empty !== (i == NUM) || almost_empty !== ((NUM - i) < AE) || full !== 1'b0) begin
        n_fail++; $display("FAIL drain_flags: empty %b aempty %b full %b at level %0d", empty, almost_empty, full, NUM - i); end
    end
    step(1'b0, 1'b1, '0);
    n_checks++; if (usedw !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL underflow_ignore: usedw %0d empty %b want 0/1", usedw, empty); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] w;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, W'($urandom));
      n_checks++; if (usedw !== 5'd5 || empty !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL simul_usedw: got %0d want 5", usedw); end
      n_checks++; if (q !== mq[0]) begin n_fail++; $display("FAIL simul_q: got %h want %h", q, mq[0]); end
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (q !== mq[0]) begin n_fail++; $display("FAIL simul_drain_q: got %h want %h", q, mq[0]); end
      step(1'b0, 1'b1, '0);
    end
    w = W'($urandom);
    step(1'b1, 1'b1, w);
    n_checks++; if (usedw !== 5'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL empty_rw_usedw: got %0d/%b want 1/0", usedw, empty); end
    n_checks++; if (q !== w) begin n_fail++; $display("FAIL empty_rw_q: got %h want %h", q, w); end
    step(1'b0, 1'b1, '0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'($urandom));
    for (int i = 0; i < 100; i++) begin
      n_checks++; if (q !== mq[0]) begin n_fail++; $display("FAIL wrap_q: got %h want %h", q, mq[0]); end
      step(1'b1, 1'b1, W'($urandom));
      n_checks++; if (usedw !== 5'd3 || gray_wr_ptr !== exp_gw || gray_rd_ptr !== exp_gr) begin
        n_fail++; $display("FAIL wrap_state: usedw %0d gw %h gr %h want 3 %h %h", usedw, gray_wr_ptr, gray_rd_ptr, exp_gw, exp_gr); end
    end
    while (mq.size() > 0) begin
      n_checks++; if (q !== mq[0]) begin n_fail++; $display("FAIL wrap_drain_q: got %h want %h", q, mq[0]); end
      step(1'b0, 1'b1, '0);
    end
  endtask

  task automatic test_gray();
    logic [LD-1:0] seq [8];
    logic [LD-1:0] prev;
    seq = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4};
    pulse_reset();
    prev = gray_wr_ptr;
    for (int k = 1; k <= 33; k++) begin
      step(1'b1, (k > 1), W'(k));
      n_checks++; if (gray_wr_ptr !== exp_gw) begin n_fail++; $display("FAIL gray_model: step %0d got %b want %b", k, gray_wr_ptr, exp_gw); end
      if (k <= 8) begin
        n_checks++; if (gray_wr_ptr !== seq[k-1]) begin n_fail++; $display("FAIL gray_table: step %0d got %b want %b", k, gray_wr_ptr, seq[k-1]); end
      end
      if (k >= 2) begin
        n_checks++; if ($countones(gray_wr_ptr ^ prev) != 1) begin n_fail++; $display("FAIL gray_onebit: %b -> %b", prev, gray_wr_ptr); end
      end
      if (k == 32) begin
        n_checks++; if (gray_wr_ptr !== 5'b10000) begin n_fail++; $display("FAIL gray_31: got %b want 10000", gray_wr_ptr); end
      end
      if (k == 33) begin
        n_checks++; if (gray_wr_ptr !== 5'b00000) begin n_fail++; $display("FAIL gray_wrap0: got %b want 00000", gray_wr_ptr); end
      end
      prev = gray_wr_ptr;
    end
    step(1'b0, 1'b1, '0);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, W'($urandom));
    n_checks++; if (usedw !== 5'd12) begin n_fail++; $display("FAIL mid_pre_usedw: got %0d want 12", usedw); end
    aclr_n = 1'b0; #1;
    n_checks++; if (usedw !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_flags: usedw %0d e %b f %b ae %b af %b", usedw, empty, full, almost_empty, almost_full); end
    n_checks++; if (gray_wr_ptr !== 5'd0 || gray_rd_ptr !== 5'd0) begin n_fail++; $display("FAIL mid_reset_gray: %h %h want 0 0", gray_wr_ptr, gray_rd_ptr); end
    #1 aclr_n = 1'b1;
    model_clear();
    w = W'($urandom);
    step(1'b1, 1'b0, w);
    n_checks++; if (q !== w || usedw !== 5'd1) begin n_fail++; $display("FAIL mid_roundtrip_write: q %h usedw %0d want %h 1", q, usedw, w); end
    step(1'b0, 1'b1, '0);
    n_checks++; if (empty !== 1'b1 || usedw !== 5'd0) begin n_fail++; $display("FAIL mid_roundtrip_read: empty %b usedw %0d want 1 0", empty, usedw); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), W'($urandom));
      n_checks++; if (usedw !== LD'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == NUM) ||
                      almost_empty !== (mq.size() < AE) || almost_full !== (mq.size() >= AF)) begin
        n_fail++; $display("FAIL random_state: usedw %0d e %b f %b ae %b af %b model %0d", usedw, empty, full, almost_empty, almost_full, mq.size()); end
      if (mq.size() > 0) begin
        n_checks++; if (q !== mq[0]) begin n_fail++; $display("FAIL random_q: got %h want %h", q, mq[0]); end
      end
      n_checks++; if (gray_wr_ptr !== exp_gw || gray_rd_ptr !== exp_gr) begin
        n_fail++; $display("FAIL random_gray: %h %h want %h %h", gray_wr_ptr, gray_rd_ptr, exp_gw, exp_gr); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_gray();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
